// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, opcode legality check and the
// sharing controller's FSM state type.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_share_state_t;

  function automatic logic alu_op_legal(input logic [CTRL_W-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALU.sv
// Existing combinational ALU datapath; unsupported opcodes yield X, which
// callers must mask.
module ALU
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [CTRL_W-1:0] ALU_CTRL,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZEROFLAG
);

  always_comb begin
    RESULT = 'x;
    case (ALU_CTRL)
      ALU_AND:   RESULT = A & B;
      ALU_OR:    RESULT = A | B;
      ALU_ADD:   RESULT = A + B;
      ALU_SUB:   RESULT = A - B;
      ALU_PASSB: RESULT = B;
      ALU_NOR:   RESULT = ~(A | B);
      default:   RESULT = 'x;
    endcase
  end

  assign ZEROFLAG = (RESULT == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester controller sharing one ALU: arbitrate, register operands,
// execute, return a registered response. Define ALU_SHARE_RR_EN for round-robin.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            REQ_VALID,
  output logic [1:0]            REQ_READY,
  input  logic [2*DATA_W-1:0]   REQ_A,
  input  logic [2*DATA_W-1:0]   REQ_B,
  input  logic [2*CTRL_W-1:0]   REQ_CTRL,
  input  logic [2*TAG_W-1:0]    REQ_TAG,
  output logic [1:0]            RSP_VALID,
  input  logic [1:0]            RSP_READY,
  output logic [DATA_W-1:0]     RSP_RESULT,
  output logic                  RSP_ZERO,
  output logic                  RSP_ERR,
  output logic [TAG_W-1:0]      RSP_TAG
);

  alu_share_state_t    state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                owner_q, owner_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                grant_c;
  logic                op_legal_c;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
`ifdef ALU_SHARE_RR_EN
  logic                last_q, last_d;
`endif

  ALU #(.DATA_W(DATA_W)) u_alu (
    .A        (a_q),
    .B        (b_q),
    .ALU_CTRL (ctrl_q),
    .RESULT   (alu_result),
    .ZEROFLAG (alu_zero)
  );

  // Grant: requester 0 unless only requester 1 is valid (or RR says otherwise)
  always_comb begin
    grant_c = ~REQ_VALID[0];
`ifdef ALU_SHARE_RR_EN
    if (&REQ_VALID) grant_c = ~last_q;
`endif
  end

  assign REQ_READY  = (state_q == IDLE && RST_N) ? (REQ_VALID & {grant_c, ~grant_c}) : 2'b00;
  assign op_legal_c = alu_op_legal(ctrl_q);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    tag_d        = tag_q;
    owner_d      = owner_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
`ifdef ALU_SHARE_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|REQ_READY) begin
          a_d     = grant_c ? REQ_A[2*DATA_W-1:DATA_W]       : REQ_A[DATA_W-1:0];
          b_d     = grant_c ? REQ_B[2*DATA_W-1:DATA_W]       : REQ_B[DATA_W-1:0];
          ctrl_d  = grant_c ? REQ_CTRL[2*CTRL_W-1:CTRL_W]    : REQ_CTRL[CTRL_W-1:0];
          tag_d   = grant_c ? REQ_TAG[2*TAG_W-1:TAG_W]       : REQ_TAG[TAG_W-1:0];
          owner_d = grant_c;
`ifdef ALU_SHARE_RR_EN
          last_d  = grant_c;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Illegal opcodes leave the ALU output undefined; mask it here
        rsp_result_d = op_legal_c ? alu_result : '0;
        rsp_zero_d   = op_legal_c & alu_zero;
        rsp_err_d    = ~op_legal_c;
        rsp_tag_d    = tag_q;
        rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
        state_d      = RESP;
      end
      RESP: begin
        if (RSP_READY[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      tag_q        <= '0;
      owner_q      <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
`ifdef ALU_SHARE_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      tag_q        <= tag_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
`ifdef ALU_SHARE_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_ZERO   = rsp_zero_q;
  assign RSP_ERR    = rsp_err_q;
  assign RSP_TAG    = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; arbitration expectations follow ALU_SHARE_RR_EN.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 4;

  logic              CLK, RST_N;
  logic [1:0]        REQ_VALID, REQ_READY, RSP_VALID, RSP_READY;
  logic [2*DW-1:0]   REQ_A, REQ_B;
  logic [7:0]        REQ_CTRL;
  logic [2*TW-1:0]   REQ_TAG;
  logic [DW-1:0]     RSP_RESULT;
  logic              RSP_ZERO, RSP_ERR;
  logic [TW-1:0]     RSP_TAG;

  int checks = 0;
  int failures = 0;

  alu_share_ctrl #(.DATA_W(DW), .TAG_W(TW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CTRL(REQ_CTRL), .REQ_TAG(REQ_TAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR), .RSP_TAG(RSP_TAG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drives a request from requester `who` until accepted; returns at the EXEC-cycle negedge.
  task automatic drive_req(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] ctrl, input logic [TW-1:0] tag, output bit ok);
    @(negedge CLK);
    REQ_VALID[who] = 1'b1;
    REQ_A[who*DW +: DW] = a;
    REQ_B[who*DW +: DW] = b;
    REQ_CTRL[who*4 +: 4] = ctrl;
    REQ_TAG[who*TW +: TW] = tag;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (REQ_READY[who]) begin
        ok = 1'b1;
        @(posedge CLK);
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    REQ_VALID[who] = 1'b0;
  endtask

  task automatic consume(input int who);
    RSP_READY[who] = 1'b1;
    @(posedge CLK);
    #1;
    RSP_READY = 2'b00;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    REQ_VALID = 2'b11;
    RSP_READY = 2'b00;
    REQ_A = '0; REQ_B = '0; REQ_CTRL = '0; REQ_TAG = '0;
    #12;
    checks++; if (REQ_READY !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", REQ_READY); end
    checks++; if (RSP_VALID !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", RSP_VALID); end
    checks++; if (RSP_RESULT !== '0 || RSP_ZERO !== 1'b0 || RSP_ERR !== 1'b0 || RSP_TAG !== '0) begin
      failures++; $display("FAIL reset_rsp_fields got=%h/%b/%b/%h exp=0/0/0/0", RSP_RESULT, RSP_ZERO, RSP_ERR, RSP_TAG);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
    RST_N = 1'b1;
  endtask

  task automatic test_add;
    bit ok;
    drive_req(0, 64'd5, 64'd7, ALU_ADD, 4'd3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL add_accept got=0 exp=1"); end
    #1;
    checks++; if (RSP_VALID !== 2'b00) begin failures++; $display("FAIL add_exec_valid got=%b exp=00", RSP_VALID); end
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01) begin failures++; $display("FAIL add_latency got=%b exp=01", RSP_VALID); end
    checks++; if (RSP_RESULT !== 64'd12 || RSP_ZERO !== 1'b0 || RSP_ERR !== 1'b0 || RSP_TAG !== 4'd3) begin
      failures++; $display("FAIL add_rsp got=%h/%b/%b/%h exp=c/0/0/3", RSP_RESULT, RSP_ZERO, RSP_ERR, RSP_TAG);
    end
    consume(0);
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b00) begin failures++; $display("FAIL add_rsp_drop got=%b exp=00", RSP_VALID); end
  endtask

  task automatic test_sub_stall;
    bit ok;
    drive_req(1, 64'h1234, 64'h1234, ALU_SUB, 4'd5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sub_accept got=0 exp=1"); end
    REQ_VALID[0] = 1'b1;
    REQ_A[DW-1:0] = 64'hF0F0; REQ_B[DW-1:0] = 64'hFF00; REQ_CTRL[3:0] = ALU_AND; REQ_TAG[TW-1:0] = 4'd7;
    #1;
    checks++; if (REQ_READY !== 2'b00) begin failures++; $display("FAIL sub_exec_ready got=%b exp=00", REQ_READY); end
    @(negedge CLK);
    RSP_READY = 2'b01;
    #1;
    checks++; if (RSP_VALID !== 2'b10 || RSP_RESULT !== '0 || RSP_ZERO !== 1'b1 || RSP_ERR !== 1'b0 || RSP_TAG !== 4'd5) begin
      failures++; $display("FAIL sub_rsp got=%b/%h/%b/%b/%h exp=10/0/1/0/5", RSP_VALID, RSP_RESULT, RSP_ZERO, RSP_ERR, RSP_TAG);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); #1;
      checks++;
      if (RSP_VALID !== 2'b10 || RSP_RESULT !== '0 || RSP_ZERO !== 1'b1 || RSP_TAG !== 4'd5 || REQ_READY !== 2'b00) begin
        failures++; $display("FAIL sub_stall_c%0d got=%b/%h/%b/%h rdy=%b exp=10/0/1/5 rdy=00",
                             c, RSP_VALID, RSP_RESULT, RSP_ZERO, RSP_TAG, REQ_READY);
      end
    end
    RSP_READY = 2'b10;
    @(posedge CLK); #1;
    RSP_READY = 2'b00;
    @(negedge CLK); #1;
    checks++; if (REQ_READY !== 2'b01 || RSP_VALID !== 2'b00) begin
      failures++; $display("FAIL sub_pending_accept got=rdy %b vld %b exp=rdy 01 vld 00", REQ_READY, RSP_VALID);
    end
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 2'b00;
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01 || RSP_RESULT !== 64'hF000 || RSP_TAG !== 4'd7) begin
      failures++; $display("FAIL pending_and_rsp got=%b/%h/%h exp=01/f000/7", RSP_VALID, RSP_RESULT, RSP_TAG);
    end
    consume(0);
  endtask

  task automatic test_error_then_or;
    bit ok;
    drive_req(0, 64'h55, 64'h66, 4'b0011, 4'd9, ok);
    checks++; if (!ok) begin failures++; $display("FAIL err_accept got=0 exp=1"); end
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01 || RSP_ERR !== 1'b1 || RSP_RESULT !== '0 || RSP_ZERO !== 1'b0 || RSP_TAG !== 4'd9) begin
      failures++; $display("FAIL err_rsp got=%b/%b/%h/%b/%h exp=01/1/0/0/9", RSP_VALID, RSP_ERR, RSP_RESULT, RSP_ZERO, RSP_TAG);
    end
    consume(0);
    drive_req(1, 64'hF0, 64'h0F, ALU_OR, 4'd2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL or_accept got=0 exp=1"); end
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b10 || RSP_RESULT !== 64'hFF || RSP_ERR !== 1'b0 || RSP_ZERO !== 1'b0 || RSP_TAG !== 4'd2) begin
      failures++; $display("FAIL or_rsp got=%b/%h/%b/%b/%h exp=10/ff/0/0/2", RSP_VALID, RSP_RESULT, RSP_ERR, RSP_ZERO, RSP_TAG);
    end
    consume(1);
  endtask

  task automatic test_arbitration;
    logic [1:0] grants [4];
    logic [1:0] exp_g  [4];
    int acc_cyc [4];
    int n = 0;
    int cyc = 0;
`ifdef ALU_SHARE_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    REQ_A = {64'd100, 64'd1}; REQ_B = {64'd200, 64'd2};
    REQ_CTRL = {ALU_ADD, ALU_ADD}; REQ_TAG = {4'd1, 4'd0};
    REQ_VALID = 2'b11;
    RSP_READY = 2'b11;
    while (n < 4 && cyc < 40) begin
      @(negedge CLK); #1;
      cyc++;
      if (REQ_READY !== 2'b00) begin
        grants[n] = REQ_READY;
        acc_cyc[n] = cyc;
        n++;
      end
    end
    @(posedge CLK); #1;
    REQ_VALID = 2'b00;
    repeat (3) @(negedge CLK);
    RSP_READY = 2'b00;
    checks++; if (n != 4) begin failures++; $display("FAIL arb_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (grants[i] !== exp_g[i]) begin failures++; $display("FAIL arb_grant%0d got=%b exp=%b", i, grants[i], exp_g[i]); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          failures++; $display("FAIL arb_period%0d got=%0d exp=3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_passb_nor;
    bit ok;
    drive_req(0, 64'hFFFF, 64'h0, ALU_PASSB, 4'd1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL passb_accept got=0 exp=1"); end
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01 || RSP_RESULT !== '0 || RSP_ZERO !== 1'b1 || RSP_ERR !== 1'b0) begin
      failures++; $display("FAIL passb_rsp got=%b/%h/%b/%b exp=01/0/1/0", RSP_VALID, RSP_RESULT, RSP_ZERO, RSP_ERR);
    end
    consume(0);
    drive_req(0, 64'h0, 64'h0, ALU_NOR, 4'd8, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nor_accept got=0 exp=1"); end
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01 || RSP_RESULT !== 64'hFFFF_FFFF_FFFF_FFFF || RSP_ZERO !== 1'b0 || RSP_TAG !== 4'd8) begin
      failures++; $display("FAIL nor_rsp got=%b/%h/%b/%h exp=01/ffffffffffffffff/0/8", RSP_VALID, RSP_RESULT, RSP_ZERO, RSP_TAG);
    end
    consume(0);
  endtask

  task automatic test_reset_midop;
    bit ok;
    drive_req(0, 64'd1, 64'd2, ALU_ADD, 4'd4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midop_accept got=0 exp=1"); end
    #2;
    RST_N = 1'b0;
    REQ_VALID = 2'b11;
    #1;
    checks++; if (REQ_READY !== 2'b00 || RSP_VALID !== 2'b00) begin
      failures++; $display("FAIL midop_reset_hs got=rdy %b vld %b exp=00 00", REQ_READY, RSP_VALID);
    end
    checks++; if (RSP_RESULT !== '0 || RSP_ZERO !== 1'b0 || RSP_ERR !== 1'b0 || RSP_TAG !== '0) begin
      failures++; $display("FAIL midop_reset_fields got=%h/%b/%b/%h exp=0/0/0/0", RSP_RESULT, RSP_ZERO, RSP_ERR, RSP_TAG);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      checks++; if (RSP_VALID !== 2'b00) begin failures++; $display("FAIL midop_no_rsp_c%0d got=%b exp=00", c, RSP_VALID); end
    end
    REQ_A = {64'd50, 64'd10}; REQ_B = {64'd60, 64'd20};
    REQ_CTRL = {ALU_ADD, ALU_ADD}; REQ_TAG = {4'd11, 4'd6};
    REQ_VALID = 2'b11;
    #1;
    checks++; if (REQ_READY !== 2'b01) begin failures++; $display("FAIL post_reset_grant got=%b exp=01", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 2'b00;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (RSP_VALID !== 2'b01 || RSP_RESULT !== 64'd30 || RSP_TAG !== 4'd6) begin
      failures++; $display("FAIL post_reset_rsp got=%b/%h/%h exp=01/1e/6", RSP_VALID, RSP_RESULT, RSP_TAG);
    end
    consume(0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_stall();
    test_error_then_or();
    test_arbitration();
    test_passb_nor();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that shares one 64-bit ALU instance between independent masters (e.g. an integer execute stage and an address-generation unit). Arbitrates request handshakes, registers operands, sequences the ALU through a three-state FSM and returns the result, zero flag and error status on a per-requester response handshake. Sits between the requesters and the single `ALU` datapath instance.

## Interface
Parameters:
- `DATA_W`, 64, operand/result width; must equal the ALU width.
- `TAG_W`, 4, opaque request tag width; echoed on the response.

Ports (index `i` in {0,1}; vectors are packed, requester 0 in the low slice):
- `CLK` in 1 — single clock, rising edge.
- `RST_N` in 1 — asynchronous, active-low reset.
- `REQ_VALID` in 2 — request valid per requester.
- `REQ_READY` out 2 — request accepted this cycle when `REQ_VALID[i] & REQ_READY[i]`.
- `REQ_A` in 2*DATA_W — operand A per requester.
- `REQ_B` in 2*DATA_W — operand B per requester.
- `REQ_CTRL` in 2*4 — ALU opcode per requester.
- `REQ_TAG` in 2*TAG_W — request tag.
- `RSP_VALID` out 2 — response valid, one-hot or zero.
- `RSP_READY` in 2 — response consumed when `RSP_VALID[i] & RSP_READY[i]`.
- `RSP_RESULT` out DATA_W — shared result bus, valid with `RSP_VALID`.
- `RSP_ZERO` out 1 — result equals zero.
- `RSP_ERR` out 1 — opcode unsupported.
- `RSP_TAG` out TAG_W — tag of the served request.

## Operation
- FSM states: `IDLE`, `EXEC`, `RESP`. Reset state `IDLE`.
- `IDLE`:
  - Arbiter picks grant `g` among asserted `REQ_VALID`.
  - `REQ_READY[g]=1` only if `REQ_VALID[g]=1`; `REQ_READY` may depend combinationally on `REQ_VALID`.
  - On handshake: capture A, B, CTRL, TAG and owner `g` into registers, go to `EXEC`.
  - No valid request: stay in `IDLE`.
- `EXEC`:
  - ALU inputs driven only from the captured registers.
  - At the clock edge, capture RESULT, ZEROFLAG and error, then go to `RESP`.
- `RESP`:
  - `RSP_VALID[owner]=1`; `RSP_RESULT`, `RSP_ZERO`, `RSP_ERR`, `RSP_TAG` held stable until the handshake.
  - On `RSP_READY[owner]` go to `IDLE`.
  - `RSP_READY` of the non-owner is ignored.
- Supported opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR.
- Any other opcode: `RSP_ERR=1`, `RSP_RESULT=0`, `RSP_ZERO=0`. The controller never forwards X from the ALU default arm.
- ADD/SUB wrap modulo 2^DATA_W; no carry or overflow output.
- `REQ_READY=0` in `EXEC` and `RESP`. Requests stay pending and must hold their payload.

## Timing
- Reset values: `REQ_READY=0`, `RSP_VALID=0`, `RSP_RESULT=0`, `RSP_ZERO=0`, `RSP_ERR=0`, `RSP_TAG=0`, FSM `IDLE`, RR pointer = 1 (requester 0 wins first).
- Latency: request handshake at cycle t gives `RSP_VALID` at t+2.
- With `RSP_READY` held high, the response handshake is at t+2, the next accept at t+3, for a minimum period of 3 cycles per operation.
- `RSP_READY` low: stay in `RESP` indefinitely with all response outputs stable.
- Both `REQ_VALID` asserted in the same cycle: exactly one `REQ_READY` asserted.
- `RST_N` asserted in any state: immediate return to reset values. The in-flight operation is dropped and no response is produced.
- `RST_N` deassertion is synchronised externally; the first accept is possible on the first edge after release.

## Configuration
- `ALU_SHARE_RR_EN` defined: round-robin arbitration.
  - If both requesters are valid, grant the one not served last.
  - Pointer updates only on a request handshake.
- `ALU_SHARE_RR_EN` undefined: fixed priority, requester 0 always wins. The pointer register is not built.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_PASSB`, `ALU_NOR`.
  - Function `alu_op_legal`.
  - FSM state enum `alu_share_state_t`.
- One sub-module: the existing `ALU`, instantiated once. Arbitration, FSM and registers stay in `alu_share_ctrl`.

## Test plan
- Req0 ADD A=5, B=7, tag 3 → `RSP_VALID[0]` two cycles after accept; RESULT=12, ZERO=0, ERR=0, TAG=3.
- Req1 SUB A=B=0x1234 → RESULT=0, ZERO=1. With `RSP_READY[1]` low for 5 cycles, outputs stay stable and `REQ_READY` stays 0 throughout.
- Both valid every cycle, RR enabled → grants alternate 0,1,0,1. With macro undefined → all four grants go to 0 while req0 keeps requesting.
- Req0 CTRL=0011 → ERR=1, RESULT=0, ZERO=0. The following req1 OR 0xF0|0x0F returns 0xFF, ERR=0.
- Assert `RST_N` low during `EXEC` → all outputs 0 the same cycle and no response after release. The first post-reset contention is won by req0.
- Req0 pass-B with A=0xFFFF, B=0 → RESULT=0, ZERO=1. Req0 NOR with A=B=0 → RESULT all ones, ZERO=0.
